// File: rtl/alu_pkg.sv
// alu_pkg: operation encoding, FSM states and op classification for alu_iterative.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SUB = 4'b0011,
      OP_SLL = 4'b0100,
      OP_SRL = 4'b0101,
      OP_XOR = 4'b0110,
      OP_SRA = 4'b0111,
      OP_BEQ = 4'b1000,
      OP_BNE = 4'b1001,
      OP_BLT = 4'b1010,
      OP_BGE = 4'b1011,
      OP_SLT = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } alu_state_e;

   function automatic logic is_shift(alu_op_e op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: single-cycle logic, arithmetic, compare and branch-condition results.
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [3:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic                  o_branch
);

   logic [DATA_WIDTH-1:0] w_diff;
   logic                  w_lt;

   assign w_diff = i_a - i_b;
   assign w_lt   = $signed(i_a) < $signed(i_b);

   // Shifts and undefined codes fall through to zero; the top handles shifts.
   always_comb begin
      o_result = '0;
      o_branch = 1'b0;
      case (i_op)
         OP_AND: o_result = i_a & i_b;
         OP_OR:  o_result = i_a | i_b;
         OP_ADD: o_result = i_a + i_b;
         OP_SUB: o_result = w_diff;
         OP_XOR: o_result = i_a ^ i_b;
         OP_SLT: o_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
         OP_BEQ: begin o_result = w_diff; o_branch = (w_diff == '0); end
         OP_BNE: begin o_result = w_diff; o_branch = (w_diff != '0); end
         OP_BLT: begin o_result = w_diff; o_branch = w_lt; end
         OP_BGE: begin o_result = w_diff; o_branch = !w_lt; end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_iterative.sv
// alu_iterative: valid/ready ALU; single-cycle ops via alu_comb_core,
// shifts one bit per cycle through an iterative shift register.
module alu_iterative
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  branch_taken,
   output logic                  zero
);

   localparam int SHAMT_W = $clog2(DATA_WIDTH);

   alu_state_e            r_state;
   logic [DATA_WIDTH-1:0] r_sh;
   logic [SHAMT_W-1:0]    r_cnt;
   logic [3:0]            r_op;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_branch;
   logic                  r_zero;

   logic [DATA_WIDTH-1:0] w_core_result;
   logic                  w_core_branch;
   logic [DATA_WIDTH-1:0] w_val;
   logic [DATA_WIDTH-1:0] w_sh_next;
   logic [SHAMT_W-1:0]    w_shamt;
   logic                  w_shift;

   alu_comb_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
      .i_op     (Operation),
      .i_a      (src_a),
      .i_b      (src_b),
      .o_result (w_core_result),
      .o_branch (w_core_branch)
   );

   assign w_shamt = src_b[SHAMT_W-1:0];
   assign w_shift = is_shift(alu_op_e'(Operation));
   // A shift by zero completes immediately with src_a unchanged.
   assign w_val   = w_shift ? src_a : w_core_result;

   always_comb begin
      w_sh_next = (r_op == OP_SLL) ? {r_sh[DATA_WIDTH-2:0], 1'b0}
                                   : {(r_op == OP_SRA) & r_sh[DATA_WIDTH-1], r_sh[DATA_WIDTH-1:1]};
   end

   assign in_ready     = (r_state == S_IDLE) && !reset;
   assign out_valid    = (r_state == S_DONE);
   assign result       = r_result;
   assign branch_taken = r_branch;
   assign zero         = r_zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_sh     <= '0;
         r_cnt    <= '0;
         r_op     <= '0;
         r_result <= '0;
         r_branch <= 1'b0;
         r_zero   <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (w_shift && w_shamt != '0) begin
                     r_sh    <= src_a;
                     r_cnt   <= w_shamt;
                     r_op    <= Operation;
                     r_state <= S_SHIFT;
                  end else begin
                     r_result <= w_val;
                     r_branch <= w_core_branch;
                     r_zero   <= (w_val == '0);
                     r_state  <= S_DONE;
                  end
               end
            end
            S_SHIFT: begin
               r_sh  <= w_sh_next;
               r_cnt <= r_cnt - 1'b1;
               // Last step: publish the final shifted value directly.
               if (r_cnt == SHAMT_W'(1)) begin
                  r_result <= w_sh_next;
                  r_branch <= 1'b0;
                  r_zero   <= (w_sh_next == '0);
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: directed vectors with hand-computed results, latencies and handshakes.
module tb_alu_iterative;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        branch_taken;
   logic        zero;

   int n_checks = 0;
   int n_errors = 0;

   alu_iterative #(.DATA_WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .Operation    (Operation),
      .src_a        (src_a),
      .src_b        (src_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .branch_taken (branch_taken),
      .zero         (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op with out_ready=1 and check result, flags, latency and handshake.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_br, input int exp_lat);
      int lat;
      int rdy_low;
      check({tag, ".rdy_in"}, 32'(in_ready), 32'd1);
      Operation = op;
      src_a     = a;
      src_b     = b;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      Operation = 4'hF;
      src_a     = ~a;
      src_b     = ~b;
      lat       = 1;
      rdy_low   = 0;
      while (!out_valid && lat < 100) begin
         if (!in_ready) rdy_low++;
         tick();
         lat++;
      end
      if (!in_ready) rdy_low++;
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".rdy_low"}, 32'(rdy_low), 32'(exp_lat));
      check({tag, ".res"}, result, exp_res);
      check({tag, ".br"}, 32'(branch_taken), 32'(exp_br));
      check({tag, ".zero"}, 32'(zero), 32'(exp_res == 32'd0));
      tick();
      check({tag, ".ov_after"}, 32'(out_valid), 32'd0);
      check({tag, ".rdy_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      Operation = 4'h0;
      src_a     = '0;
      src_b     = '0;
      tick();
      tick();
      check("rst.ov", 32'(out_valid), 32'd0);
      check("rst.res", result, 32'd0);
      check("rst.br", 32'(branch_taken), 32'd0);
      check("rst.zero", 32'(zero), 32'd1);
      check("rst.rdy", 32'(in_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("rst.rdy_rel", 32'(in_ready), 32'd1);

      run_op("add",  4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1);
      run_op("sub",  4'b0011, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1);
      run_op("and",  4'b0000, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  1'b0, 1);
      run_op("or",   4'b0001, 32'hF000_0001,  32'h0000_0100,  32'hF000_0101,  1'b0, 1);
      run_op("sra4", 4'b0111, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 5);
      run_op("sra+", 4'b0111, 32'h4000_0000,  32'd2,          32'h1000_0000,  1'b0, 3);
      run_op("sll0", 4'b0100, 32'd1,          32'd0,          32'd1,          1'b0, 1);
      run_op("sll31",4'b0100, 32'd1,          32'h0000_00FF,  32'h8000_0000,  1'b0, 32);
      run_op("srl4", 4'b0101, 32'h8000_00F0,  32'd4,          32'h0800_000F,  1'b0, 5);
      run_op("blt",  4'b1010, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFE,  1'b1, 1);
      run_op("bge",  4'b1011, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFE,  1'b0, 1);
      run_op("beq",  4'b1000, 32'd9,          32'd9,          32'd0,          1'b1, 1);
      run_op("bne",  4'b1001, 32'd9,          32'd9,          32'd0,          1'b0, 1);
      run_op("slt",  4'b1100, 32'hFFFF_FFFE,  32'd3,          32'd1,          1'b0, 1);
      run_op("sltn", 4'b1100, 32'd3,          32'hFFFF_FFFE,  32'd0,          1'b0, 1);
      run_op("undef",4'b1110, 32'd5,          32'd6,          32'd0,          1'b0, 1);

      // Backpressure: outputs hold while inputs churn and in_valid stays high.
      out_ready = 1'b0;
      Operation = 4'b0110;
      src_a     = 32'hF0;
      src_b     = 32'hFF;
      in_valid  = 1'b1;
      tick();
      check("bp.ov", 32'(out_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         Operation = 4'(i);
         src_a     = 32'(i * 17 + 3);
         src_b     = 32'(i + 100);
         tick();
         check("bp.hold_res", result, 32'h0F);
         check("bp.hold_ov", 32'(out_valid), 32'd1);
         check("bp.hold_rdy", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp.rel_ov", 32'(out_valid), 32'd0);
      check("bp.rel_rdy", 32'(in_ready), 32'd1);

      // Reset mid-shift discards the op.
      Operation = 4'b0101;
      src_a     = 32'hFFFF_FFFF;
      src_b     = 32'd20;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("rs.busy", 32'(in_ready), 32'd0);
      reset = 1'b1;
      tick();
      check("rs.ov", 32'(out_valid), 32'd0);
      check("rs.res", result, 32'd0);
      check("rs.zero", 32'(zero), 32'd1);
      reset = 1'b0;
      #1;
      check("rs.rdy", 32'(in_ready), 32'd1);
      for (int i = 0; i < 25; i++) tick();
      check("rs.no_out", 32'(out_valid), 32'd0);

      run_op("post", 4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Sequential ALU: the execute stage that directly consumes the 4-bit `Operation` code from the ALU controller, plus the two operands from the register-read/immediate mux. It computes logic, arithmetic, compare and branch-condition results. Non-shift ops complete in one cycle; shifts run one bit per cycle through an iterative shifter. The block uses a valid/ready handshake on input and output so the multicycle core can stall around it.

## Interface
- `DATA_WIDTH`, 32: operand and result width; must be a power of two ≥ 8.
- `SHAMT_W`, $clog2(DATA_WIDTH): shift-amount width; derived, not overridden.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and `Operation` valid this cycle.
- `in_ready`  out  1  block can accept; a transfer happens when `in_valid && in_ready`.
- `Operation`  in  4  ALU operation code (encoding below).
- `src_a`  in  DATA_WIDTH  operand A (rs1 / PC).
- `src_b`  in  DATA_WIDTH  operand B (rs2 / immediate); shifts use `src_b[SHAMT_W-1:0]`.
- `out_valid`  out  1  `result` / `branch_taken` / `zero` valid.
- `out_ready`  in  1  consumer accepts; a transfer happens when `out_valid && out_ready`.
- `result`  out  DATA_WIDTH  ALU result.
- `branch_taken`  out  1  branch condition true (branch ops only, else 0).
- `zero`  out  1  `result == 0`.

## Operation
- Encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLL, 0101 SRL, 0110 XOR, 0111 SRA, 1000 BEQ, 1001 BNE, 1010 BLT, 1011 BGE, 1100 SLT. Codes 1101–1111 are undefined: they give `result`=0, `branch_taken`=0, and take one cycle.
- Arithmetic is modulo 2^DATA_WIDTH with no overflow flag.
- BLT, BGE and SLT compare signed. SLT gives a result of 1 or 0, zero-extended.
- Branch ops set `branch_taken` and produce `result` = `src_a - src_b`.
- SRA replicates `src_a[DATA_WIDTH-1]`. SRL and SLL fill with zeros.
- FSM states:
  - IDLE: `in_ready`=1.
    - On a transfer with a non-shift op, or a shift with shamt 0: latch the result and go to DONE.
    - On a transfer with a shift and shamt k>0: load the shift register with `src_a`, set the counter to k, and go to SHIFT.
  - SHIFT: shift one bit per cycle and decrement the counter. When the counter reaches 0, go to DONE. `in_ready`=0.
  - DONE: `out_valid`=1. Outputs are held stable until `out_ready`. On the output transfer, go to IDLE. `in_ready`=0.
- Inputs are sampled only on the input transfer. Later changes to `src_a`, `src_b` or `Operation` have no effect on the op in flight.

## Timing
- Reset: state IDLE, `out_valid`=0, `result`=0, `branch_taken`=0, `zero`=1, counter=0.
- `in_ready` = (state==IDLE) && !reset, so it is 0 during the reset cycle.
- Latency, measured from the input-transfer edge to the first cycle with `out_valid`=1:
  - non-shift op, or shamt 0: 1 cycle;
  - shift with shamt k: 1+k cycles (maximum DATA_WIDTH, i.e. 1+(DATA_WIDTH-1)).
- Throughput: one op in flight at a time.
  - An input transfer cannot happen in the same cycle as the output transfer.
  - The earliest next accept is the cycle after the output transfer.
  - Back-to-back non-shift ops therefore take 2 cycles each when `out_ready`=1.
- Backpressure: with `out_ready`=0 in DONE, all outputs stay bit-stable indefinitely.
- Reset asserted in any state, including mid-SHIFT or in DONE with a pending output, returns to reset values on the next edge. The in-flight op is discarded.

## Structure
- Package `alu_pkg` holds:
  - `alu_op_e`, a 4-bit enum with the encoding above;
  - `alu_state_e` (IDLE, SHIFT, DONE);
  - a helper function `is_shift(alu_op_e)`.
- Sub-module `alu_comb_core` is purely combinational: single-cycle ops and `branch_taken` from (op, a, b).
- `alu_iterative` instantiates `alu_comb_core` and contains the FSM, shift register, counter and output registers.

## Test plan
- ADD 5+7, with `out_ready`=1: `out_valid` one cycle after accept, `result`=12, `zero`=0. Then SUB 3-5 gives 0xFFFFFFFE.
- SRA 0x80000000 by 4: `in_ready` low for 5 cycles, `out_valid` 5 cycles after accept, `result`=0xF8000000. SLL 0x1 by 0 gives 0x1 with latency 1.
- BLT -1 vs 1 gives `branch_taken`=1. BGE -1 vs 1 gives 0. BEQ 9 vs 9 gives `branch_taken`=1 and `zero`=1. SLT -2 vs 3 gives `result`=1.
- Backpressure: after XOR 0xF0 ^ 0xFF, hold `out_ready`=0 for 3 cycles and toggle the inputs. Required: `result`=0x0F stable, `in_ready`=0, no new accept. Release: transfer, then IDLE the next cycle.
- Reset during SHIFT (SRL by 20, reset at cycle 6): next edge gives IDLE, `out_valid`=0, `result`=0. `in_ready`=1 the cycle after reset deasserts.
- Undefined op 1110: `result`=0, `branch_taken`=0, latency 1.
